// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - parametrised UART receiver with parity/frame/break detection feeding a valid/ready FIFO
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_L,
    input  logic                 i_RX_Serial,
    output logic                 o_RX_Valid,
    input  logic                 i_RX_Ready,
    output logic [DATA_BITS-1:0] o_RX_Data,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Overrun,
    output logic                 o_Busy
);
    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W  = DATA_BITS + 2;
    localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE} state_t;

    logic                 rx_meta, rx_sync;
    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [3:0]           bit_idx, idx_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic                 par_err, perr_next;
    logic                 frm_err, ferr_next;
    logic                 push;
    logic [ENT_W-1:0]     push_entry;

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            rx_meta <= i_RX_Serial;
            rx_sync <= rx_meta;
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= idx_next;
            shift   <= shift_next;
            par_err <= perr_next;
            frm_err <= ferr_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = bit_idx;
        shift_next = shift;
        perr_next  = par_err;
        ferr_next  = frm_err;
        push       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_sync) begin
                    state_next = S_START;
                    cnt_next   = '0;
                end
            end
            S_START: begin
                // A start bit that is high again at mid-bit is a glitch, not a frame
                if (cnt == HALF_CNT) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    perr_next  = 1'b0;
                    ferr_next  = 1'b0;
                    state_next = rx_sync ? S_IDLE : S_DATA;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt == FULL_CNT) begin
                    cnt_next   = '0;
                    shift_next = {rx_sync, shift[DATA_BITS-1:1]};
                    if (bit_idx == LAST_DATA) begin
                        idx_next   = '0;
                        state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_next = bit_idx + 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            S_PARITY: begin
                if (cnt == FULL_CNT) begin
                    cnt_next   = '0;
                    perr_next  = (PARITY == 1) ? ~(^shift ^ rx_sync) : (^shift ^ rx_sync);
                    state_next = S_STOP;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt == FULL_CNT) begin
                    cnt_next  = '0;
                    ferr_next = frm_err | ~rx_sync;
                    if (bit_idx == LAST_STOP) begin
                        push       = 1'b1;
                        idx_next   = '0;
                        state_next = rx_sync ? S_IDLE : S_WAIT_IDLE;
                    end else begin
                        idx_next = bit_idx + 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (rx_sync) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign push_entry = {shift, par_err, ferr_next};
    assign o_Busy     = (state != S_IDLE);

    logic [ENT_W-1:0]  mem [FIFO_DEPTH];
    logic [ADDR_W:0]   wr_ptr, rd_ptr;
    logic [ENT_W-1:0]  head;
    logic              full, empty, pop, push_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign pop     = !empty && i_RX_Ready;
    assign push_ok = push && (!full || pop);

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            o_Overrun <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            o_Overrun <= push && full && !pop;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (push_ok) mem[wr_ptr[ADDR_W-1:0]] <= push_entry;
    end

    // Storage is not reset, so head fields are forced to zero while empty
    assign head         = mem[rd_ptr[ADDR_W-1:0]];
    assign o_RX_Valid   = !empty;
    assign o_RX_Data    = empty ? '0 : head[ENT_W-1:2];
    assign o_Parity_Err = !empty && head[1];
    assign o_Frame_Err  = !empty && head[0];
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver: the next generation of the team's fixed 8N1 receiver. It adds configurable data width, parity and stop bits, start-bit glitch rejection, and framing/parity error and break detection. Received words go into a small FIFO drained over a valid/ready interface. It sits between the board RX pin and the command decoder, which may stall without losing bytes, up to the FIFO depth.

## Interface

Parameters:
- CLKS_PER_BIT, 217 — clock cycles per bit (25 MHz / 115200); legal range ≥ 4
- DATA_BITS, 8 — data bits per frame; legal 5..9
- PARITY, 0 — 0 none, 1 odd, 2 even
- STOP_BITS, 1 — 1 or 2
- FIFO_DEPTH, 4 — entries; power of two, ≥ 2

Ports:
- i_Clock, in, 1 — single clock; all logic rising-edge
- i_Rst_L, in, 1 — asynchronous assert, active-low reset
- i_RX_Serial, in, 1 — asynchronous serial line, idle high
- o_RX_Valid, out, 1 — FIFO head valid
- i_RX_Ready, in, 1 — consumer accepts head when high with o_RX_Valid
- o_RX_Data, out, DATA_BITS — head data, bit 0 = first received
- o_Parity_Err, out, 1 — head entry's parity check failed (0 when PARITY=0)
- o_Frame_Err, out, 1 — head entry's stop bit sampled low
- o_Overrun, out, 1 — one-cycle pulse: completed frame dropped, FIFO full
- o_Busy, out, 1 — receiver FSM not in IDLE

## Operation

- Input passes a 2-flop synchroniser; both flops reset to 1. All FSM decisions use the synchronised bit.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: on synchronised low, go to START and clear the bit counter.
- START: sample at count (CLKS_PER_BIT-1)/2.
  - Low: reset the counter and go to DATA.
  - High: glitch; return to IDLE with nothing pushed.
- Sampling: every subsequent bit is sampled after CLKS_PER_BIT cycles, i.e. mid-bit.
- DATA: shift in DATA_BITS bits, LSB first.
  - Next state is PARITY if PARITY≠0, else STOP.
- PARITY: sample the parity bit.
  - Odd: error if XOR(data, parity bit) = 0.
  - Even: error if that XOR = 1.
- STOP: sample STOP_BITS stop bits; frame error if any is low.
  - After the last stop sample, push {data, parity_err, frame_err} into the FIFO in the same cycle.
  - Next state is IDLE if the last stop sample is high, else WAIT_IDLE.
- WAIT_IDLE (break / low line): stay until the synchronised line is high, then go to IDLE. A held-low line yields exactly one frame, with data 0 and frame_err set.
- FIFO: circular buffer with read/write pointers one bit wider than the address.
  - Full = addresses equal, MSBs differ; empty = pointers equal.
  - Simultaneous push and pop when full: the pop frees a slot, so the push is accepted.
  - Push when full (no pop): frame dropped; o_Overrun high for one cycle. FIFO contents unchanged.
- Outputs o_RX_Data, o_Parity_Err and o_Frame_Err show the head entry. They are don't-care when o_RX_Valid=0.
- Pop occurs on the rising edge where o_RX_Valid & i_RX_Ready.

## Timing

- Reset (i_Rst_L low, asynchronous):
  - FSM to IDLE, counters 0, FIFO empty.
  - o_RX_Valid=0, o_RX_Data=0, o_Parity_Err=0, o_Frame_Err=0, o_Overrun=0, o_Busy=0.
  - Synchroniser flops = 1.
- Reset mid-frame discards the partial frame. Reception restarts on the first falling edge after release.
- Input to FSM latency: 2 cycles (synchroniser).
- Push occurs on the cycle of the final stop-bit sample. o_RX_Valid rises the following cycle if the FIFO was empty.
- Total latency, start-bit falling edge to o_RX_Valid: 2 + (CLKS_PER_BIT-1)/2 + CLKS_PER_BIT·(DATA_BITS + P + STOP_BITS) + 1 cycles, ±1. P = 1 if parity enabled, else 0.
- o_RX_Valid stays high, with head fields stable, until popped. The consumer may hold i_RX_Ready high continuously.
- o_Busy is combinational from the FSM state register.

## Test plan

- Reset, then 8N1 0x37 at CLKS_PER_BIT=217 (8680 ns/bit), i_RX_Ready=1 -> one o_RX_Valid cycle, o_RX_Data=0x37, both error flags 0, within the latency formula.
- PARITY=2, send 0xA5 with parity bit 1 (correct is 0) -> o_RX_Data=0xA5, o_Parity_Err=1. Repeat with parity 0 -> o_Parity_Err=0.
- Line pulsed low for 50 cycles, then high -> o_Busy pulses, then returns low; no o_RX_Valid; a following 0x5A frame is received correctly.
- Line held low for 20 bit periods, then high; then send 0x81 -> exactly two entries: 0x00 with o_Frame_Err=1, then 0x81 with no errors.
- FIFO_DEPTH=4, i_RX_Ready=0, send 0x01..0x05 -> o_Overrun pulses once, after frame 5. Raising i_RX_Ready then pops 0x01, 0x02, 0x03, 0x04 in order, and o_RX_Valid falls.
- DATA_BITS=7, STOP_BITS=2, PARITY=1: send 0x55, then a second 0x55 frame whose second stop bit is low -> first entry has no errors; second has o_Frame_Err=1. Assert i_Rst_L low mid-way through a third frame -> all outputs 0 immediately, and the next clean frame is received.
